// File: rtl/vending_ctrl_if.sv
// Customer, coin and slot-programming signals of the vending controller.
// master drives stimulus/configuration, slave is the controller itself.
interface vending_ctrl_if #(
    parameter int NUM_PROD = 4,
    parameter int STOCK_W  = 3,
    parameter int CREDIT_W = 7
);
    localparam int IDX_W = $clog2(NUM_PROD);

    logic                start;
    logic [IDX_W-1:0]    product;
    logic                coin5;
    logic                coin10;
    logic                cancel;

    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [CREDIT_W-1:0] cfg_cost;
    logic [STOCK_W-1:0]  cfg_stock;

    logic                issue_prod;
    logic                not_available;
    logic                change5;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output start, product, coin5, coin10, cancel,
        output cfg_we, cfg_idx, cfg_cost, cfg_stock,
        input  issue_prod, not_available, change5, coin_reject, busy, credit
    );

    modport slave (
        input  start, product, coin5, coin10, cancel,
        input  cfg_we, cfg_idx, cfg_cost, cfg_stock,
        output issue_prod, not_available, change5, coin_reject, busy, credit
    );
endinterface

// File: rtl/vending_ctrl.sv
// Vending machine controller: slot select, coin credit, vend and change return.
// Define VEND_REFUND_EN to let cancel abort a collection with a full refund.
module vending_ctrl #(
    parameter int NUM_PROD   = 4,
    parameter int STOCK_W    = 3,
    parameter int CREDIT_W   = 7,
    parameter int INIT_STOCK = 2
) (
    input logic           clk,
    input logic           reset,
    vending_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PROD);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]    sel;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] cost  [NUM_PROD];
    logic [STOCK_W-1:0]  stock [NUM_PROD];
    logic                coin5_q;
    logic                coin10_q;
    logic                coin_reject;

    logic                sel_ok;
    logic [CREDIT_W-1:0] sel_cost;
    logic                sel_empty;
    logic                cfg_ok;
    logic                abort;
    logic                has_change;
    logic [CREDIT_W:0]   coin_add;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ovf;

`ifdef VEND_REFUND_EN
    assign abort = bus.cancel;
`else
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign abort         = 1'b0;
`endif

    // An out-of-range slot (non power-of-two NUM_PROD) reads as empty.
    assign sel_ok     = int'(sel) < NUM_PROD;
    assign sel_cost   = sel_ok ? cost[sel] : '0;
    assign sel_empty  = !sel_ok || (stock[sel] == '0);
    assign cfg_ok     = int'(bus.cfg_idx) < NUM_PROD;
    assign has_change = credit >= CREDIT_W'(5);

    always_comb begin
        coin_add = '0;
        if (bus.coin5 && !coin5_q) begin
            coin_add = coin_add + (CREDIT_W+1)'(5);
        end
        if (bus.coin10 && !coin10_q) begin
            coin_add = coin_add + (CREDIT_W+1)'(10);
        end
        coin_sum = {1'b0, credit} + coin_add;
        coin_ovf = coin_sum[CREDIT_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = sel_empty ? IDLE : COLLECT;
            end
            COLLECT: begin
                // Cancel takes priority over a completed payment.
                if (abort) begin
                    state_nx = CHANGE;
                end else if (credit >= sel_cost) begin
                    state_nx = VEND;
                end
            end
            VEND: begin
                state_nx = CHANGE;
            end
            CHANGE: begin
                if (!has_change) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy          = state != IDLE;
        bus.issue_prod    = state == VEND;
        bus.not_available = (state == CHECK) && sel_empty;
        bus.change5       = (state == CHANGE) && has_change;
        bus.coin_reject   = coin_reject;
        bus.credit        = credit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel         <= '0;
            credit      <= '0;
            coin5_q     <= 1'b0;
            coin10_q    <= 1'b0;
            coin_reject <= 1'b0;
            for (int unsigned i = 0; i < NUM_PROD; i++) begin
                cost[i]  <= CREDIT_W'((i + 1) * 5);
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            // Edge history keeps tracking in every state so a held level never credits later.
            coin5_q     <= bus.coin5;
            coin10_q    <= bus.coin10;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sel <= bus.product;
                    end else if (bus.cfg_we && cfg_ok) begin
                        cost[bus.cfg_idx]  <= bus.cfg_cost;
                        stock[bus.cfg_idx] <= bus.cfg_stock;
                    end
                end
                COLLECT: begin
                    if (coin_add != '0) begin
                        if (coin_ovf) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= coin_sum[CREDIT_W-1:0];
                        end
                    end
                end
                VEND: begin
                    credit <= credit - sel_cost;
                    if (!sel_empty) begin
                        stock[sel] <= stock[sel] - STOCK_W'(1);
                    end
                end
                CHANGE: begin
                    credit <= has_change ? credit - CREDIT_W'(5) : '0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PROD, default 4, number of product slots (2..16).
REQ-002 The block SHALL have parameter STOCK_W, default 3, width of each per-slot stock counter.
REQ-003 The block SHALL have parameter CREDIT_W, default 7, width of the credit accumulator, in currency units.
REQ-004 The block SHALL have parameter INIT_STOCK, default 2, stock loaded into every slot at reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have ports start (in, 1, begin transaction), product (in, clog2(NUM_PROD), slot select), coin5 (in, 1, 5-unit coin level), coin10 (in, 1, 10-unit coin level), and cancel (in, 1, abort request).
REQ-008 The block SHALL have ports cfg_we (in, 1), cfg_idx (in, clog2(NUM_PROD)), cfg_cost (in, CREDIT_W), and cfg_stock (in, STOCK_W) as the slot programming port.
REQ-009 The block SHALL have outputs issue_prod (1), not_available (1), change5 (1, one 5-unit coin returned per asserted cycle), coin_reject (1), busy (1), and credit (CREDIT_W).

Function
REQ-010 States SHALL be IDLE, CHECK, COLLECT, VEND, and CHANGE; busy=1 in every state except IDLE.
REQ-011 IDLE: start=1 latches product into sel; next state is CHECK; start in any other state is ignored.
REQ-012 CHECK: stock[sel]==0 -> not_available=1 for exactly that cycle, then IDLE; otherwise COLLECT.
REQ-013 Coins SHALL be rising-edge detected (registered previous level); a held level credits once.
REQ-014 COLLECT: each coin5 edge adds 5 and each coin10 edge adds 10; simultaneous edges add 15 in the same cycle.
REQ-015 If an add would exceed 2^CREDIT_W-1, the whole add is discarded, credit is unchanged, and coin_reject=1 for one cycle.
REQ-016 Coin edges outside COLLECT SHALL be ignored; the edge detector keeps tracking.
REQ-017 COLLECT with credit >= cost[sel] (registered credit) -> VEND next cycle; cost 0 vends after one COLLECT cycle.
REQ-018 VEND (exactly one cycle): issue_prod=1, stock[sel] decrements by 1, and credit reduces by cost[sel]; next state is CHANGE.
REQ-019 CHANGE: while credit >= 5, change5=1 and credit reduces by 5 each cycle; when credit < 5, credit clears to 0 (residue forfeited) and the next state is IDLE.
REQ-020 issue_prod, not_available, change5, and busy SHALL be Moore decodes of state; coin_reject SHALL be registered.
REQ-021 cfg_we=1 in IDLE with no start in the same cycle writes cost[cfg_idx] and stock[cfg_idx]; cfg_we is ignored otherwise, and start wins over cfg_we.
REQ-022 cfg_cost SHALL be a multiple of 5; other values are outside the supported use.
REQ-023 Stock SHALL never wrap; a slot at 0 is only reachable via not_available.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, credit=0, sel=0, all outputs 0, edge registers 0, cost[i]=(i+1)*5, and stock[i]=INIT_STOCK, including mid-transaction; no change is returned for the aborted credit.

Configuration
REQ-025 With macro VEND_REFUND_EN defined, cancel=1 in COLLECT SHALL go to CHANGE with credit intact (full refund in 5-unit pulses) and no issue_prod; cancel overrides the credit>=cost check in the same cycle.
REQ-026 Without VEND_REFUND_EN, cancel SHALL be ignored, and the port remains present but unused.

Verification
REQ-027 Slot 0 (cost 5), start, then coin10 edge -> VEND one cycle (issue_prod=1), one change5 pulse, then IDLE; stock[0] goes 2->1.
REQ-028 Slot 3 (cost 20): coin5 edge, then a simultaneous coin5+coin10 edge -> credit goes 5->20, issue_prod once, zero change5 pulses.
REQ-029 Vend slot 1 twice (stock 2->0), third start on slot 1 -> not_available=1 for one cycle and credit stays 0.
REQ-030 Credit 120 (CREDIT_W=7) plus a coin10 edge -> coin_reject=1, credit stays 120; reset asserted mid-COLLECT -> credit=0, IDLE, busy=0 asynchronously.
REQ-031 VEND_REFUND_EN defined: slot 3, credit 15, cancel -> three change5 pulses, no issue_prod, stock unchanged; without the macro, cancel has no effect.
REQ-032 cfg_we in IDLE setting cost[2]=0 and stock[2]=1, then start on slot 2 -> issue_prod with no coins, stock[2]=0; cfg_we while busy -> no change.
